seq_input_checker: RTL and testbench

//   Player-side counterpart of the 4-bit one-hot sequence table: reads player button presses,

---
 rtl/seq_input_checker.sv | 159 +++++++++++++++
 tb/tb_seq_input_checker.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_input_checker.sv
// -----------------------------------------------------------------------------
// seq_input_checker
//   Player-side checker for the one-hot sequence game. It steps through the
//   sequence table, debounces each button press and compares it with the table
//   output. Each turn ends with exactly one result pulse: a correct full round,
//   a wrong press, or a timeout.
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   start      in   1  1-cycle pulse that begins a turn (ignored while busy)
//   round_len  in   4  last table address checked this turn, latched on start
//   botoes     in   4  synchronised buttons, active high, bit i = colour i
//   seq_data   in   4  one-hot table value at 'address' (combinational)
//   address    out  4  registered table address
//   busy       out  1  high from accepted start until the turn ends
//   match      out  1  1-cycle pulse: whole round correct
//   erro       out  1  1-cycle pulse: wrong or multi-button press
//   timeout    out  1  1-cycle pulse: no press within TIMEOUT cycles
// -----------------------------------------------------------------------------
module seq_input_checker #(
  parameter int DEB_CYCLES = 3,
  parameter int TIMEOUT    = 50000000,
  parameter int TW         = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] round_len,
  input  logic [3:0] botoes,
  input  logic [3:0] seq_data,
  output logic [3:0] address,
  output logic       busy,
  output logic       match,
  output logic       erro,
  output logic       timeout
);

  localparam int DW = $clog2(DEB_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PRESS,
    WAIT_RELEASE,
    DONE_OK,
    DONE_ERR,
    DONE_TO
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [DW-1:0] deb_cnt;   // identical nonzero samples seen so far, incl. last one
  logic [3:0]    prev;      // previous botoes sample
  logic [3:0]    rlen;      // round_len latched at start

  logic          same_nz;
  logic [DW-1:0] run_cur;   // run length including the current sample
  logic          accept;
  logic          multi;

  // A run of identical nonzero samples grows by one per cycle; any change
  // restarts it (at 1 if the new value is nonzero, else 0).
  assign same_nz = (botoes != 4'd0) && (botoes == prev);
  assign run_cur = same_nz            ? deb_cnt + DW'(1) :
                   (botoes != 4'd0)   ? DW'(1)           : '0;
  assign accept  = (state == WAIT_PRESS) && (run_cur == DW'(DEB_CYCLES));
  assign multi   = (botoes & (botoes - 4'd1)) != 4'd0;

  // NOTE: all state and outputs are updated with non-blocking assignments so
  // every branch below reads the values from before this clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      address <= 4'd0;
      busy    <= 1'b0;
      match   <= 1'b0;
      erro    <= 1'b0;
      timeout <= 1'b0;
      timer   <= '0;
      deb_cnt <= '0;
      prev    <= 4'd0;
      rlen    <= 4'd0;
    end else begin
      // Result pulses default low; only the transitions into DONE_* raise one.
      match   <= 1'b0;
      erro    <= 1'b0;
      timeout <= 1'b0;

      case (state)
        IDLE: begin
          address <= 4'd0;
          busy    <= 1'b0;
          if (start) begin
            rlen    <= round_len;
            timer   <= '0;
            deb_cnt <= '0;
            prev    <= 4'd0;
            busy    <= 1'b1;
            state   <= WAIT_PRESS;
          end
        end

        WAIT_PRESS: begin
          prev    <= botoes;
          deb_cnt <= run_cur;
          // An accepted press takes priority over a timeout in the same cycle.
          if (accept) begin
            timer <= '0;
            if (multi || (botoes != seq_data)) begin
              erro    <= 1'b1;
              busy    <= 1'b0;
              address <= 4'd0;
              state   <= DONE_ERR;
            end else begin
              state <= WAIT_RELEASE;
            end
          end else if (timer == TW'(TIMEOUT - 1)) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            address <= 4'd0;
            state   <= DONE_TO;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        WAIT_RELEASE: begin
          timer <= '0;
          if (botoes == 4'd0) begin
            if (address == rlen) begin
              match   <= 1'b1;
              busy    <= 1'b0;
              address <= 4'd0;
              state   <= DONE_OK;
            end else begin
              address <= address + 4'd1;
              deb_cnt <= '0;
              prev    <= 4'd0;
              state   <= WAIT_PRESS;
            end
          end
        end

        DONE_OK, DONE_ERR, DONE_TO: begin
          address <= 4'd0;
          busy    <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          address <= 4'd0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_input_checker.sv
// -----------------------------------------------------------------------------
// tb_seq_input_checker
//   Drives player turns against seq_input_checker (DEB_CYCLES=2, TIMEOUT=20)
//   with a behavioural sequence table. Expected outputs come from the game
//   rules: a press is decided on its DEB-th identical sample, a correct round
//   ends one cycle after the last release, and an idle wait ends TIMEOUT
//   cycles after the turn starts.
// -----------------------------------------------------------------------------
module tb_seq_input_checker;

  localparam int DEB = 2;
  localparam int TO  = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] round_len;
  logic [3:0] botoes;
  logic [3:0] seq_data;
  logic [3:0] address;
  logic       busy, match, erro, timeout;

  logic [3:0] tbl [16];
  assign seq_data = tbl[address];

  int errors = 0;
  int checks = 0;

  wire [7:0] obs = {busy, match, erro, timeout, address};

  seq_input_checker #(.DEB_CYCLES(DEB), .TIMEOUT(TO), .TW(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .round_len(round_len),
    .botoes(botoes), .seq_data(seq_data), .address(address), .busy(busy),
    .match(match), .erro(erro), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ex(input logic b, input logic m, input logic e,
                                    input logic t, input int a);
    return {b, m, e, t, 4'(a)};
  endfunction

  // One clock; outputs are observed 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_spec_table();
    for (int i = 0; i < 16; i++) tbl[i] = 4'b0001;
    tbl[0] = 4'b0001; tbl[1] = 4'b0100; tbl[2] = 4'b0001; tbl[3] = 4'b1000;
  endtask

  task automatic load_random_table();
    for (int i = 0; i < 16; i++) tbl[i] = 4'b0001 << $urandom_range(0, 3);
  endtask

  // Plays one turn. err_at < 0: every press correct. Otherwise the press at
  // address err_at uses 'bad'. poke_done raises start during the DONE cycle.
  task automatic play_round(input logic [3:0] rl, input int err_at,
                            input logic [3:0] bad, input bit poke_done,
                            input string nm);
    logic [7:0] e;
    logic [3:0] v;
    int gap, hold;
    round_len = rl; start = 1'b1; tick(); start = 1'b0;
    round_len = 4'($urandom);
    e = ex(1, 0, 0, 0, 0); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s start: got=%b exp=%b", nm, obs, e); end
    for (int k = 0; k <= int'(rl); k++) begin
      gap = $urandom_range(0, 4);
      repeat (gap) begin
        tick(); e = ex(1, 0, 0, 0, k); checks++;
        if (obs !== e) begin errors++; $display("FAIL %s gap a%0d: got=%b exp=%b", nm, k, obs, e); end
      end
      v = (k == err_at) ? bad : tbl[k];
      for (int j = 1; j <= DEB; j++) begin
        botoes = v; tick();
        if (j == DEB && k == err_at) e = ex(0, 0, 1, 0, 0);
        else                         e = ex(1, 0, 0, 0, k);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL %s press a%0d s%0d: got=%b exp=%b", nm, k, j, obs, e); end
      end
      if (k == err_at) begin
        botoes = 4'd0; start = poke_done; round_len = 4'd0; tick(); start = 1'b0;
        e = ex(0, 0, 0, 0, 0); checks++;
        if (obs !== e) begin errors++; $display("FAIL %s after erro: got=%b exp=%b", nm, obs, e); end
        return;
      end
      // Any nonzero value while waiting for release is just a held button.
      hold = $urandom_range(0, 3);
      repeat (hold) begin
        botoes = 4'($urandom_range(1, 15)); tick();
        e = ex(1, 0, 0, 0, k); checks++;
        if (obs !== e) begin errors++; $display("FAIL %s hold a%0d: got=%b exp=%b", nm, k, obs, e); end
      end
      botoes = 4'd0; tick();
      e = (k == int'(rl)) ? ex(0, 1, 0, 0, 0) : ex(1, 0, 0, 0, k + 1);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL %s release a%0d: got=%b exp=%b", nm, k, obs, e); end
    end
    start = poke_done; round_len = 4'd0; tick(); start = 1'b0;
    e = ex(0, 0, 0, 0, 0); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s after match: got=%b exp=%b", nm, obs, e); end
  endtask

  task automatic test_reset();
    logic [7:0] e;
    rst_n = 1'b0; start = 1'b0; botoes = 4'd0; round_len = 4'd0;
    load_spec_table();
    #1;
    e = ex(0, 0, 0, 0, 0); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset async: got=%b exp=%b", obs, e); end
    repeat (2) tick();
    rst_n = 1'b1; tick();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset release: got=%b exp=%b", obs, e); end
  endtask

  task automatic test_match();
    load_spec_table();
    play_round(4'd2, -1, 4'd0, 1'b0, "match_rl2");
    play_round(4'd0, -1, 4'd0, 1'b0, "match_rl0");
  endtask

  task automatic test_wrong();
    load_spec_table();
    play_round(4'd3, 1, 4'b1000, 1'b0, "wrong_a1");
    play_round(4'd3, 0, 4'b0101, 1'b0, "multi_a0");
  endtask

  task automatic test_glitch();
    logic [7:0] e;
    load_spec_table();
    round_len = 4'd0; start = 1'b1; tick(); start = 1'b0;
    // Single-sample glitches and alternating values never reach DEB samples.
    botoes = 4'b0001; tick(); botoes = 4'd0; tick();
    botoes = 4'b0001; tick(); botoes = 4'b0100; tick(); botoes = 4'b0001; tick();
    botoes = 4'd0; tick();
    e = ex(1, 0, 0, 0, 0); checks++;
    if (obs !== e) begin errors++; $display("FAIL glitch: got=%b exp=%b", obs, e); end
    botoes = 4'b0101; tick();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL multi s1: got=%b exp=%b", obs, e); end
    tick();
    e = ex(0, 0, 1, 0, 0); checks++;
    if (obs !== e) begin errors++; $display("FAIL multi erro: got=%b exp=%b", obs, e); end
    botoes = 4'd0; tick();
  endtask

  task automatic test_timeout();
    logic [7:0] e;
    load_spec_table();
    // Idle turn: timeout pulse exactly TO cycles after start is accepted.
    round_len = 4'd1; start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= TO; c++) begin
      tick();
      e = (c == TO) ? ex(0, 0, 0, 1, 0) : ex(1, 0, 0, 0, 0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL timeout c%0d: got=%b exp=%b", c, obs, e); end
    end
    tick(); e = ex(0, 0, 0, 0, 0); checks++;
    if (obs !== e) begin errors++; $display("FAIL timeout end: got=%b exp=%b", obs, e); end
    // Press completing on the last allowed cycle wins over the timeout; a
    // long hold does not time out; the timer restarts at the next address.
    round_len = 4'd1; start = 1'b1; tick(); start = 1'b0;
    repeat (TO - DEB) tick();
    botoes = 4'b0001; repeat (DEB) tick();
    e = ex(1, 0, 0, 0, 0); checks++;
    if (obs !== e) begin errors++; $display("FAIL deadline press: got=%b exp=%b", obs, e); end
    repeat (TO + 5) tick();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL long hold: got=%b exp=%b", obs, e); end
    botoes = 4'd0; tick();
    for (int c = 1; c <= TO; c++) begin
      tick();
      e = (c == TO) ? ex(0, 0, 0, 1, 0) : ex(1, 0, 0, 0, 1);
      if (c >= TO - 1) begin
        checks++;
        if (obs !== e) begin errors++; $display("FAIL timeout a1 c%0d: got=%b exp=%b", c, obs, e); end
      end
    end
    tick();
  endtask

  task automatic test_restart_ignored();
    logic [7:0] e;
    load_spec_table();
    round_len = 4'd3; start = 1'b1; tick(); start = 1'b0;
    botoes = 4'b0001; repeat (DEB) tick(); botoes = 4'd0; tick();
    round_len = 4'd0; start = 1'b1; tick(); start = 1'b0;
    e = ex(1, 0, 0, 0, 1); checks++;
    if (obs !== e) begin errors++; $display("FAIL restart ignored: got=%b exp=%b", obs, e); end
    // If round_len had been re-latched to 0, this release would end the round.
    botoes = 4'b0100; repeat (DEB) tick(); botoes = 4'd0; tick();
    e = ex(1, 0, 0, 0, 2); checks++;
    if (obs !== e) begin errors++; $display("FAIL no relatch a2: got=%b exp=%b", obs, e); end
    botoes = 4'b0001; repeat (DEB) tick(); botoes = 4'd0; tick();
    botoes = 4'b1000; repeat (DEB) tick(); botoes = 4'd0; tick();
    e = ex(0, 1, 0, 0, 0); checks++;
    if (obs !== e) begin errors++; $display("FAIL no relatch match: got=%b exp=%b", obs, e); end
    tick();
  endtask

  task automatic test_mid_reset();
    logic [7:0] e;
    load_spec_table();
    round_len = 4'd3; start = 1'b1; tick(); start = 1'b0;
    botoes = 4'b0001; repeat (DEB) tick(); botoes = 4'd0; tick();
    botoes = 4'b0100; repeat (DEB) tick(); botoes = 4'd0; tick();
    botoes = 4'b0001; tick();
    e = ex(1, 0, 0, 0, 2); checks++;
    if (obs !== e) begin errors++; $display("FAIL pre reset: got=%b exp=%b", obs, e); end
    #2 rst_n = 1'b0;
    #1 e = ex(0, 0, 0, 0, 0); checks++;
    if (obs !== e) begin errors++; $display("FAIL mid reset async: got=%b exp=%b", obs, e); end
    tick(); rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) botoes = 4'd0;
      tick(); checks++;
      if (obs !== e) begin errors++; $display("FAIL post reset idle c%0d: got=%b exp=%b", c, obs, e); end
    end
    play_round(4'd3, -1, 4'd0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    load_spec_table();
    play_round(4'd1, -1, 4'd0, 1'b1, "b2b_match");
    play_round(4'd2, 2, 4'b0010, 1'b1, "b2b_erro");
    play_round(4'd0, -1, 4'd0, 1'b0, "b2b_next");
  endtask

  task automatic test_random();
    int rl, ea;
    logic [3:0] bad;
    for (int r = 0; r < 12; r++) begin
      load_random_table();
      rl = $urandom_range(0, 15);
      ea = -1;
      bad = 4'd0;
      if ($urandom_range(0, 2) == 0) begin
        ea = $urandom_range(0, rl);
        if ($urandom_range(0, 1) == 0) begin
          do bad = 4'($urandom_range(1, 15)); while ($countones(bad) < 2);
        end else begin
          bad = {tbl[ea][2:0], tbl[ea][3]};
        end
      end
      play_round(4'(rl), ea, bad, 1'($urandom_range(0, 1)), $sformatf("rand%0d", r));
    end
  endtask

  initial begin
    test_reset();
    test_match();
    test_wrong();
    test_glitch();
    test_timeout();
    test_restart_ignored();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
